// File: rtl/restoring_divider.sv
// Sequential unsigned divider: restoring shift-subtract, one quotient bit per clock.
// Start/done handshake; results are held until the next accepted start.
module restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       state_o
);

  // Handshake: start is sampled on a rising edge only while the block is in
  // IDLE or DONE (busy=0); done is a one-cycle pulse marking quotient,
  // remainder and div_by_zero valid, and those outputs hold until the next
  // accepted start replaces them.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_shift, r_step;
  logic [WIDTH-1:0] q_step;

  // One restoring step; compare/subtract are WIDTH+1 bits wide so R never overflows.
  always_comb begin
    r_shift = (r_q << 1) | {{WIDTH{1'b0}}, q_q[WIDTH-1]};
    q_step  = q_q << 1;
    r_step  = r_shift;
    if (r_shift >= {1'b0, d_q}) begin
      r_step    = r_shift - {1'b0, d_q};
      q_step[0] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = CALC;
            r_d     = '0;
            q_d     = dividend;
            d_d     = divisor;
            count_d = '0;
          end
        end
      end
      CALC: begin
        r_d     = r_step;
        q_d     = q_step;
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) begin
          state_d     = DONE;
          count_d     = '0;
          quotient_d  = q_step;
          remainder_d = r_step[WIDTH-1:0];
          dbz_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign state_o     = state_q;

endmodule
